// File: rtl/seq_scan_pkg.sv
// Shared definitions for the serial pattern-scan controller: FSM state
// encoding and the pattern value loaded at reset.
package seq_scan_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Pattern value after reset; the oldest window bit is compared to bit 4.
    localparam logic [4:0] SEQ_PAT_RST = 5'b10110;

endpackage

// File: rtl/seq_window_match.sv
// Bit-serial window matcher: keeps the last PAT_W bits, a saturating fill
// count and a registered (masked) compare against the pattern.
module seq_window_match
    import seq_scan_pkg::*;
#(
    parameter int PAT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bit_in,
    input  logic             bit_en,
    input  logic             clr_fill,
    input  logic [PAT_W-1:0] pattern,
    input  logic [PAT_W-1:0] mask,
    output logic             match
);

    localparam int FILL_W = $clog2(PAT_W + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);

    logic [PAT_W-1:0]  window_reg, window_next;
    logic [FILL_W-1:0] fill_reg, fill_next;
    logic              match_reg, match_next;
    logic [PAT_W-1:0]  diff;

    // Next window/fill: newest bit enters at the LSB, oldest sits at the MSB.
    always_comb begin
        window_next = window_reg;
        fill_next   = fill_reg;
        if (bit_en) begin
            window_next = {window_reg[PAT_W-2:0], bit_in};
            if (fill_reg != FILL_FULL) begin
                fill_next = fill_reg + FILL_W'(1);
            end
        end
        if (clr_fill) begin
            fill_next = '0;
        end
    end

    // Per-bit mismatch, ignoring positions whose mask bit is 0.
    genvar gi;
    generate
        for (gi = 0; gi < PAT_W; gi++) begin : g_cmp
            assign diff[gi] = (window_next[gi] ^ pattern[gi]) & mask[gi];
        end
    endgenerate

    // A match is only reported for the bit just shifted in, once the window is full.
    assign match_next = bit_en && (fill_next == FILL_FULL) && (diff == '0);

    // Window, fill and match registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            window_reg <= '0;
            fill_reg   <= '0;
            match_reg  <= 1'b0;
        end else begin
            window_reg <= window_next;
            fill_reg   <= fill_next;
            match_reg  <= match_next;
        end
    end

    assign match = match_reg;

endmodule

// File: rtl/seq_scan_ctrl.sv
// Word-to-bit scan controller: accepts words over valid/ready, serialises
// them MSB first into seq_window_match, counts matches and pulses done.
// Optional build macro SEQ_SCAN_MASK_EN adds a cfg_mask don't-care mask.
module seq_scan_ctrl
    import seq_scan_pkg::*;
#(
    parameter int                DATA_W  = 16,
    parameter int                PAT_W   = 5,
    parameter int                CNT_W   = 8,
    parameter logic [PAT_W-1:0]  PAT_RST = PAT_W'(SEQ_PAT_RST)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_we,
    input  logic [PAT_W-1:0]  cfg_pattern,
`ifdef SEQ_SCAN_MASK_EN
    input  logic [PAT_W-1:0]  cfg_mask,
`endif
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              cnt_clr,
    output logic              busy,
    output logic              match,
    output logic              done,
    output logic [CNT_W-1:0]  match_cnt,
    output logic [1:0]        State
);

    localparam int BIDX_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t             state_reg, state_next;
    logic [DATA_W-1:0]  shreg_reg, shreg_next;
    logic [BIDX_W-1:0]  bit_idx_reg, bit_idx_next;
    logic [PAT_W-1:0]   pattern_reg, pattern_next;
    logic [PAT_W-1:0]   mask_eff;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic               bit_en;
    logic               clr_fill;

`ifdef SEQ_SCAN_MASK_EN
    logic [PAT_W-1:0]   mask_reg, mask_next;
    assign mask_eff = mask_reg;
`else
    assign mask_eff = '1;
`endif

    // FSM next state, serialiser and configuration loads (config only in IDLE).
    always_comb begin
        state_next   = state_reg;
        shreg_next   = shreg_reg;
        bit_idx_next = bit_idx_reg;
        pattern_next = pattern_reg;
`ifdef SEQ_SCAN_MASK_EN
        mask_next    = mask_reg;
`endif
        in_ready     = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        bit_en       = 1'b0;
        clr_fill     = 1'b0;
        case (state_reg)
            IDLE: begin
                in_ready = 1'b1;
                if (cfg_we) begin
                    pattern_next = cfg_pattern;
`ifdef SEQ_SCAN_MASK_EN
                    mask_next    = cfg_mask;
`endif
                    clr_fill     = 1'b1;
                end
                if (in_valid) begin
                    shreg_next   = in_data;
                    bit_idx_next = BIDX_W'(DATA_W - 1);
                    state_next   = SHIFT;
                end
            end
            SHIFT: begin
                busy         = 1'b1;
                bit_en       = 1'b1;
                shreg_next   = {shreg_reg[DATA_W-2:0], 1'b0};
                bit_idx_next = bit_idx_reg - BIDX_W'(1);
                if (bit_idx_reg == '0) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Saturating match counter; a clear beats a coincident match.
    always_comb begin
        cnt_next = cnt_reg;
        if (cnt_clr) begin
            cnt_next = '0;
        end else if (match && (cnt_reg != CNT_MAX)) begin
            cnt_next = cnt_reg + CNT_W'(1);
        end
    end

    // Control and configuration registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            shreg_reg   <= '0;
            bit_idx_reg <= '0;
            pattern_reg <= PAT_RST;
            cnt_reg     <= '0;
`ifdef SEQ_SCAN_MASK_EN
            mask_reg    <= '1;
`endif
        end else begin
            state_reg   <= state_next;
            shreg_reg   <= shreg_next;
            bit_idx_reg <= bit_idx_next;
            pattern_reg <= pattern_next;
            cnt_reg     <= cnt_next;
`ifdef SEQ_SCAN_MASK_EN
            mask_reg    <= mask_next;
`endif
        end
    end

    seq_window_match #(
        .PAT_W (PAT_W)
    ) u_match (
        .clk      (clk),
        .rst      (rst),
        .bit_in   (shreg_reg[DATA_W-1]),
        .bit_en   (bit_en),
        .clr_fill (clr_fill),
        .pattern  (pattern_reg),
        .mask     (mask_eff),
        .match    (match)
    );

    assign match_cnt = cnt_reg;
    assign State     = state_reg;

endmodule
